// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the execute stage.
//   ALUOp codes, R-type funct codes, E_in bit positions, multiply/divide FSM
//   state type and the DIVU_EN build flag derived from macro EX_DIVU_EN.
package ex_pkg;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_RTYPE = 2'b10;
    localparam logic [1:0] OP_ORI   = 2'b11;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_SLT   = 6'h2A;

    localparam int E_REGDST    = 3;
    localparam int E_ALUSRC    = 2;
    localparam int E_ALUOP_MSB = 1;
    localparam int E_ALUOP_LSB = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } md_state_t;

`ifdef EX_DIVU_EN
    localparam bit DIVU_EN = 1'b1;
`else
    localparam bit DIVU_EN = 1'b0;
`endif

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-cycle unsigned multiply (shift-add) and divide
//   (restoring) with architectural HI/LO result registers.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_start       multu/divu present in execute (only acted on in IDLE)
//   i_op          0 = multu, 1 = divu
//   i_a, i_b      rs / rt operands, latched at start
//   o_busy        FSM in BUSY
//   o_done        FSM in DONE (result just written)
//   o_hi, o_lo    HI/LO registers
// Macro EX_DIVU_EN: when undefined the divide datapath is not built and
//   divide requests are ignored.
module muldiv_unit
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    md_state_t   r_state;
    logic [4:0]  r_count;
    logic [31:0] r_acc;
    logic [31:0] r_q;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        w_go;
    logic [32:0] w_sum;
    logic [31:0] w_acc_nx;
    logic [31:0] w_q_nx;

    // Multiply: r_acc:r_q is the 64-bit partial product, r_q starts as the
    // multiplier and shifts out one bit per step while r_b (multiplicand)
    // is conditionally added into the upper half.
    assign w_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : 33'd0);

`ifdef EX_DIVU_EN
    logic        r_div;
    logic [32:0] w_shift;
    logic [32:0] w_diff;

    // Divide: r_acc is the partial remainder, r_q shifts the dividend out
    // and quotient bits in. A zero divisor never goes negative, so the
    // quotient saturates to all ones and the remainder ends as the dividend.
    assign w_go     = i_start;
    assign w_shift  = {r_acc, r_q[31]};
    assign w_diff   = w_shift - {1'b0, r_b};
    assign w_acc_nx = r_div ? (w_diff[32] ? w_shift[31:0] : w_diff[31:0]) : w_sum[32:1];
    assign w_q_nx   = r_div ? {r_q[30:0], ~w_diff[32]} : {w_sum[0], r_q[31:1]};

    always_ff @(posedge clk) begin
        if (rst)
            r_div <= 1'b0;
        else if (r_state == S_IDLE && w_go)
            r_div <= i_op;
    end
`else
    assign w_go     = i_start & ~i_op;
    assign w_acc_nx = w_sum[32:1];
    assign w_q_nx   = {w_sum[0], r_q[31:1]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state <= S_BUSY;
                        r_count <= '0;
                        r_acc   <= '0;
                        r_q     <= i_op ? i_a : i_b;
                        r_b     <= i_op ? i_b : i_a;
                    end
                end
                S_BUSY: begin
                    r_acc   <= w_acc_nx;
                    r_q     <= w_q_nx;
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31) begin
                        r_hi    <= w_acc_nx;
                        r_lo    <= w_q_nx;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy = r_state == S_BUSY;
    assign o_done = r_state == S_DONE;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: pipeline execute stage with ALU, HI/LO multiply/divide unit and
//   the EX/MEM pipeline register.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   W_in, M_in           writeback / memory control, passed to EX/MEM
//   E_in                 {RegDst, ALUSrc, ALUOp[1:0]}
//   rd1_in, rd2_in       register operands
//   funct_in, shamt_in   R-type function and shift amount
//   immed_in             16-bit immediate
//   rt_in, rd_in         destination register candidates
//   W_out, M_out, alu_out, wdata_out, wreg_out   EX/MEM register
//   stall                combinational; freezes upstream stages
// Macro EX_DIVU_EN: enables divu; otherwise divu retires as a bubble.
module ex_stage
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  W_in,
    input  logic [1:0]  M_in,
    input  logic [3:0]  E_in,
    input  logic [31:0] rd1_in,
    input  logic [31:0] rd2_in,
    input  logic [5:0]  funct_in,
    input  logic [4:0]  shamt_in,
    input  logic [15:0] immed_in,
    input  logic [4:0]  rt_in,
    input  logic [4:0]  rd_in,
    output logic [1:0]  W_out,
    output logic [1:0]  M_out,
    output logic [31:0] alu_out,
    output logic [31:0] wdata_out,
    output logic [4:0]  wreg_out,
    output logic        stall
);

    logic [1:0]  w_aluop;
    logic [31:0] w_b;
    logic [31:0] w_rfun;
    logic [31:0] w_alu;
    logic [31:0] w_hi;
    logic [31:0] w_lo;
    logic        w_rtype;
    logic        w_md_div;
    logic        w_md_fn;
    logic        w_md_start;
    logic        w_busy;
    logic        w_done;
    logic        w_bubble;

    assign w_aluop = E_in[E_ALUOP_MSB:E_ALUOP_LSB];
    assign w_b     = (w_aluop == OP_ORI) ? {16'h0, immed_in} :
                     E_in[E_ALUSRC] ? sext16(immed_in) : rd2_in;
    assign w_rtype = w_aluop == OP_RTYPE;

    assign w_md_div   = funct_in == F_DIVU;
    assign w_md_fn    = w_rtype && (funct_in == F_MULTU || w_md_div);
    assign w_md_start = w_rtype && (funct_in == F_MULTU || (DIVU_EN && w_md_div));

    // In DONE the same multu/divu is still presented but must not restart.
    assign stall    = w_busy || (w_md_start && !w_done);
    // multu/divu never write a GPR, so they always leave a bubble behind.
    assign w_bubble = stall || w_done || w_md_fn;

    always_comb begin
        w_rfun = '0;
        case (funct_in)
            F_ADD:   w_rfun = rd1_in + w_b;
            F_SUB:   w_rfun = rd1_in - w_b;
            F_AND:   w_rfun = rd1_in & w_b;
            F_OR:    w_rfun = rd1_in | w_b;
            F_SLT:   w_rfun = {31'd0, $signed(rd1_in) < $signed(w_b)};
            F_SLL:   w_rfun = w_b << shamt_in;
            F_SRL:   w_rfun = w_b >> shamt_in;
            F_MFHI:  w_rfun = w_hi;
            F_MFLO:  w_rfun = w_lo;
            default: w_rfun = '0;
        endcase
    end

    assign w_alu = (w_aluop == OP_ADD) ? rd1_in + w_b :
                   (w_aluop == OP_SUB) ? rd1_in - w_b :
                   w_rtype ? w_rfun : rd1_in | w_b;

    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            W_out     <= '0;
            M_out     <= '0;
            alu_out   <= '0;
            wdata_out <= '0;
            wreg_out  <= '0;
        end else begin
            W_out     <= W_in;
            M_out     <= M_in;
            alu_out   <= w_alu;
            wdata_out <= rd2_in;
            wreg_out  <= E_in[E_REGDST] ? rd_in : rt_in;
        end
    end

    muldiv_unit u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_md_start),
        .i_op    (w_md_div),
        .i_a     (rd1_in),
        .i_b     (rd2_in),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_hi    (w_hi),
        .o_lo    (w_lo)
    );

endmodule
